// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encoding,
// master-count limits and a constant-evaluable clog2 helper.
package bus_arbiter_pkg;

  // Upper bound on requesters; the master index fits in indexWidth bits.
  localparam int maxMasters = 8;
  localparam int indexWidth = 3;

  // Arbiter states with fixed 3-bit encodings.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_BEGIN = 3'd1,
    OWNED      = 3'd2,
    ABORT      = 3'd3,
    RELEASE    = 3'd4
  } arbState_t;

  // Ceiling log2, used to size the watchdog at elaboration time.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin search: finds the first requesting master
// after lastGranted, ascending with wrap-around.
module round_robin_picker
  import bus_arbiter_pkg::*;
#(
  parameter int nrOfMasters = 4
) (
  input  logic [nrOfMasters-1:0] requests,
  input  logic [indexWidth-1:0]  lastGranted,
  output logic                   found,
  output logic [indexWidth-1:0]  winner
);

  int                     candidate;
  logic [nrOfMasters-1:0] candidateMask;

  // Scan offsets 1..nrOfMasters from the last grantee; first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    found         = 1'b0;
    winner        = lastGranted;
    candidate     = 0;
    candidateMask = '0;
    for (int k = 1; k <= nrOfMasters; k++) begin
      candidate = int'(lastGranted) + k;
      if (candidate >= nrOfMasters) candidate = candidate - nrOfMasters;
      candidateMask = nrOfMasters'(1) << candidate;
      if (!found && ((requests & candidateMask) != '0)) begin
        found  = 1'b1;
        winner = indexWidth'(candidate);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus. Grants one master at a
// time, tracks ownership by snooping begin/end on the bus, and a watchdog
// forces the bus free when a grantee never starts or never finishes.
module bus_arbiter_rr
  import bus_arbiter_pkg::*;
#(
  parameter int nrOfMasters        = 4,
  parameter int beginTimeout       = 16,
  parameter int transactionTimeout = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [nrOfMasters-1:0] busRequests,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  input  logic                   busErrorIn,
  output logic [nrOfMasters-1:0] busGrants,
  output logic                   endTransactionOut,
  output logic                   busErrorOut,
  output logic [indexWidth-1:0]  activeMaster,
  output logic                   busIdle
);

  localparam int maxTimeout =
    (beginTimeout > transactionTimeout) ? beginTimeout : transactionTimeout;
  localparam int watchdogWidth = (clog2(maxTimeout) < 1) ? 1 : clog2(maxTimeout);

  localparam logic [watchdogWidth-1:0] beginLoad       = watchdogWidth'(beginTimeout - 1);
  localparam logic [watchdogWidth-1:0] transactionLoad = watchdogWidth'(transactionTimeout - 1);
  localparam logic [watchdogWidth-1:0] watchdogStep    = watchdogWidth'(1);
  localparam logic [indexWidth-1:0]    lastIndex       = indexWidth'(nrOfMasters - 1);

  // Reject master counts the index width cannot represent.
  if (nrOfMasters < 2 || nrOfMasters > maxMasters) begin : gBadMasterCount
    $error("bus_arbiter_rr: nrOfMasters must be within 2..%0d", maxMasters);
  end

  arbState_t                state;
  logic [watchdogWidth-1:0] watchdog;
  logic [indexWidth-1:0]    lastGranted;
  logic                     pickFound;
  logic [indexWidth-1:0]    pickWinner;

  round_robin_picker #(
    .nrOfMasters(nrOfMasters)
  ) picker (
    .requests   (busRequests),
    .lastGranted(lastGranted),
    .found      (pickFound),
    .winner     (pickWinner)
  );

  // Arbitration FSM with watchdog; every output is a register updated here.
  always_ff @(posedge clock) begin
    // NOTE: all state and outputs use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (reset) begin
      state             <= IDLE;
      busGrants         <= '0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
      activeMaster      <= '0;
      busIdle           <= 1'b1;
      watchdog          <= '0;
      lastGranted       <= lastIndex;
    end else begin
      // Abort pulses are single-cycle unless the ABORT entry sets them.
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
      case (state)
        IDLE: begin
          if (pickFound) begin
            state        <= WAIT_BEGIN;
            busGrants    <= nrOfMasters'(1) << pickWinner;
            activeMaster <= pickWinner;
            lastGranted  <= pickWinner;
            watchdog     <= beginLoad;
            busIdle      <= 1'b0;
          end
        end
        WAIT_BEGIN: begin
          // A begin on the final watchdog cycle still counts.
          if (beginTransactionIn) begin
            state    <= OWNED;
            watchdog <= transactionLoad;
          end else if (watchdog == '0) begin
            // No transaction started, so nothing to terminate: no pulses.
            state     <= RELEASE;
            busGrants <= '0;
          end else begin
            watchdog <= watchdog - watchdogStep;
          end
        end
        OWNED: begin
          // An end on the final watchdog cycle is a normal completion.
          if (endTransactionIn) begin
            state     <= RELEASE;
            busGrants <= '0;
          end else if (watchdog == '0) begin
            state             <= ABORT;
            busGrants         <= '0;
            endTransactionOut <= 1'b1;
            busErrorOut       <= 1'b1;
          end else if (busErrorIn) begin
            // The owner saw an error but keeps the bus until it ends.
            watchdog <= watchdog - watchdogStep;
          end else begin
            watchdog <= watchdog - watchdogStep;
          end
        end
        ABORT: begin
          state <= RELEASE;
        end
        RELEASE: begin
          state   <= IDLE;
          busIdle <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          busGrants <= '0;
          busIdle   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed self-checking bench for bus_arbiter_rr with 4 masters,
// beginTimeout=16 and transactionTimeout=64.
module tb_bus_arbiter_rr;

  logic       clock;
  logic       reset;
  logic [3:0] busRequests;
  logic       beginTransactionIn;
  logic       endTransactionIn;
  logic       busErrorIn;
  logic [3:0] busGrants;
  logic       endTransactionOut;
  logic       busErrorOut;
  logic [2:0] activeMaster;
  logic       busIdle;

  int checks   = 0;
  int failures = 0;

  bus_arbiter_rr #(
    .nrOfMasters       (4),
    .beginTimeout      (16),
    .transactionTimeout(64)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .busRequests       (busRequests),
    .beginTransactionIn(beginTransactionIn),
    .endTransactionIn  (endTransactionIn),
    .busErrorIn        (busErrorIn),
    .busGrants         (busGrants),
    .endTransactionOut (endTransactionOut),
    .busErrorOut       (busErrorOut),
    .activeMaster      (activeMaster),
    .busIdle           (busIdle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    busRequests = 4'b0000;
    beginTransactionIn = 1'b0;
    endTransactionIn = 1'b0;
    busErrorIn = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    busRequests = 4'b0000;
    beginTransactionIn = 1'b0;
    endTransactionIn = 1'b0;
    busErrorIn = 1'b0;
    step();
    step();
    checks++; if (busGrants !== 4'b0000) begin failures++; $display("FAIL reset_grants: got %b expected %b", busGrants, 4'b0000); end
    checks++; if (endTransactionOut !== 1'b0) begin failures++; $display("FAIL reset_eto: got %b expected 0", endTransactionOut); end
    checks++; if (busErrorOut !== 1'b0) begin failures++; $display("FAIL reset_beo: got %b expected 0", busErrorOut); end
    checks++; if (activeMaster !== 3'd0) begin failures++; $display("FAIL reset_active: got %0d expected 0", activeMaster); end
    checks++; if (busIdle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b expected 1", busIdle); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_request();
    busRequests = 4'b0100;
    step();
    checks++; if (busGrants !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b expected %b", busGrants, 4'b0100); end
    checks++; if (activeMaster !== 3'd2) begin failures++; $display("FAIL single_active: got %0d expected 2", activeMaster); end
    checks++; if (busIdle !== 1'b0) begin failures++; $display("FAIL single_busy: got %b expected 0", busIdle); end
    busRequests = 4'b0000;
    beginTransactionIn = 1'b1;
    step();
    beginTransactionIn = 1'b0;
    repeat (19) step();
    checks++; if (busGrants !== 4'b0100) begin failures++; $display("FAIL single_held: got %b expected %b", busGrants, 4'b0100); end
    endTransactionIn = 1'b1;
    step();
    endTransactionIn = 1'b0;
    checks++; if (busGrants !== 4'b0000) begin failures++; $display("FAIL single_release: got %b expected %b", busGrants, 4'b0000); end
    checks++; if (busIdle !== 1'b0) begin failures++; $display("FAIL single_release_idle: got %b expected 0", busIdle); end
    step();
    checks++; if (busIdle !== 1'b1) begin failures++; $display("FAIL single_idle: got %b expected 1", busIdle); end
  endtask

  task automatic test_fairness();
    int gap;
    logic [3:0] expected;
    applyReset();
    busRequests = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      expected = 4'b0001 << (i % 4);
      checks++; if (busGrants !== expected) begin failures++; $display("FAIL fair_grant%0d: got %b expected %b", i, busGrants, expected); end
      beginTransactionIn = 1'b1;
      step();
      beginTransactionIn = 1'b0;
      repeat (3) step();
      endTransactionIn = 1'b1;
      step();
      endTransactionIn = 1'b0;
      if (i < 4) begin
        gap = (busGrants == 4'b0000) ? 1 : 0;
        for (int c = 0; c < 10; c++) begin
          step();
          if (busGrants != 4'b0000) break;
          gap++;
        end
        checks++; if (gap !== 2) begin failures++; $display("FAIL fair_gap%0d: got %0d expected 2", i, gap); end
      end else begin
        busRequests = 4'b0000;
        step();
      end
    end
  endtask

  task automatic test_begin_timeout();
    logic held;
    logic pulsed;
    held = 1'b1;
    pulsed = 1'b0;
    busRequests = 4'b0010;
    step();
    busRequests = 4'b0000;
    checks++; if (busGrants !== 4'b0010) begin failures++; $display("FAIL btmo_grant: got %b expected %b", busGrants, 4'b0010); end
    for (int c = 0; c < 15; c++) begin
      step();
      if (busGrants !== 4'b0010) held = 1'b0;
      if (busErrorOut !== 1'b0 || endTransactionOut !== 1'b0) pulsed = 1'b1;
    end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL btmo_held: got %b expected 1", held); end
    step();
    checks++; if (busGrants !== 4'b0000) begin failures++; $display("FAIL btmo_drop: got %b expected %b", busGrants, 4'b0000); end
    if (busErrorOut !== 1'b0 || endTransactionOut !== 1'b0) pulsed = 1'b1;
    checks++; if (pulsed !== 1'b0) begin failures++; $display("FAIL btmo_nopulse: got %b expected 0", pulsed); end
    step();
    busRequests = 4'b1111;
    step();
    checks++; if (busGrants !== 4'b0100) begin failures++; $display("FAIL btmo_next: got %b expected %b", busGrants, 4'b0100); end
    busRequests = 4'b0000;
    beginTransactionIn = 1'b1;
    step();
    beginTransactionIn = 1'b0;
    endTransactionIn = 1'b1;
    step();
    endTransactionIn = 1'b0;
    step();
  endtask

  task automatic test_watchdog_abort();
    logic early;
    logic held;
    early = 1'b0;
    held = 1'b1;
    busRequests = 4'b1000;
    step();
    busRequests = 4'b0000;
    checks++; if (activeMaster !== 3'd3) begin failures++; $display("FAIL wd_active: got %0d expected 3", activeMaster); end
    beginTransactionIn = 1'b1;
    step();
    beginTransactionIn = 1'b0;
    for (int c = 0; c < 63; c++) begin
      step();
      if (endTransactionOut !== 1'b0 || busErrorOut !== 1'b0) early = 1'b1;
      if (busGrants !== 4'b1000) held = 1'b0;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL wd_early: got %b expected 0", early); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL wd_held: got %b expected 1", held); end
    step();
    checks++; if (endTransactionOut !== 1'b1) begin failures++; $display("FAIL wd_eto: got %b expected 1", endTransactionOut); end
    checks++; if (busErrorOut !== 1'b1) begin failures++; $display("FAIL wd_beo: got %b expected 1", busErrorOut); end
    checks++; if (busGrants !== 4'b0000) begin failures++; $display("FAIL wd_grants: got %b expected %b", busGrants, 4'b0000); end
    step();
    checks++; if ({endTransactionOut, busErrorOut} !== 2'b00) begin failures++; $display("FAIL wd_pulse_len: got %b expected 00", {endTransactionOut, busErrorOut}); end
    step();
    checks++; if (busIdle !== 1'b1) begin failures++; $display("FAIL wd_idle: got %b expected 1", busIdle); end
  endtask

  task automatic test_coincident_events();
    busRequests = 4'b0001;
    step();
    busRequests = 4'b0000;
    beginTransactionIn = 1'b1;
    step();
    beginTransactionIn = 1'b0;
    repeat (63) step();
    endTransactionIn = 1'b1;
    step();
    endTransactionIn = 1'b0;
    checks++; if ({endTransactionOut, busErrorOut} !== 2'b00) begin failures++; $display("FAIL coinc_end_nopulse: got %b expected 00", {endTransactionOut, busErrorOut}); end
    checks++; if (busGrants !== 4'b0000) begin failures++; $display("FAIL coinc_end_release: got %b expected %b", busGrants, 4'b0000); end
    step();
    checks++; if (endTransactionOut !== 1'b0) begin failures++; $display("FAIL coinc_end_later: got %b expected 0", endTransactionOut); end
    busRequests = 4'b0010;
    step();
    busRequests = 4'b0000;
    repeat (15) step();
    beginTransactionIn = 1'b1;
    step();
    beginTransactionIn = 1'b0;
    checks++; if (busGrants !== 4'b0010) begin failures++; $display("FAIL coinc_begin_owned: got %b expected %b", busGrants, 4'b0010); end
    endTransactionIn = 1'b1;
    step();
    endTransactionIn = 1'b0;
    step();
  endtask

  task automatic test_error_mid_burst();
    busRequests = 4'b0100;
    step();
    busRequests = 4'b0000;
    beginTransactionIn = 1'b1;
    step();
    beginTransactionIn = 1'b0;
    repeat (3) step();
    busErrorIn = 1'b1;
    step();
    busErrorIn = 1'b0;
    checks++; if (busGrants !== 4'b0100) begin failures++; $display("FAIL err_still_owned: got %b expected %b", busGrants, 4'b0100); end
    repeat (3) step();
    endTransactionIn = 1'b1;
    step();
    endTransactionIn = 1'b0;
    checks++; if ({busGrants, endTransactionOut, busErrorOut} !== 6'b000000) begin failures++; $display("FAIL err_release: got %b expected 000000", {busGrants, endTransactionOut, busErrorOut}); end
    step();
    checks++; if (busIdle !== 1'b1) begin failures++; $display("FAIL err_idle: got %b expected 1", busIdle); end
  endtask

  task automatic test_reset_mid_transaction();
    busRequests = 4'b0010;
    step();
    busRequests = 4'b0000;
    beginTransactionIn = 1'b1;
    step();
    beginTransactionIn = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busGrants !== 4'b0000) begin failures++; $display("FAIL rstmid_grants: got %b expected %b", busGrants, 4'b0000); end
    checks++; if (busIdle !== 1'b1) begin failures++; $display("FAIL rstmid_idle: got %b expected 1", busIdle); end
    busRequests = 4'b1001;
    step();
    busRequests = 4'b0000;
    checks++; if (busGrants !== 4'b0001) begin failures++; $display("FAIL rstmid_priority: got %b expected %b", busGrants, 4'b0001); end
    checks++; if (activeMaster !== 3'd0) begin failures++; $display("FAIL rstmid_active: got %0d expected 0", activeMaster); end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_fairness();
    test_begin_timeout();
    test_watchdog_abort();
    test_coincident_events();
    test_error_mid_burst();
    test_reset_mid_transaction();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
